// File: rtl/lapido_pkg.sv
// Shared Lapido core definitions: register address width and the stall-cause
// encoding reported by the hazard controller.
package lapido_pkg;

  localparam int REG_ADDR_W = 4;

  localparam logic [1:0] STALL_RUN      = 2'b00;
  localparam logic [1:0] STALL_LOAD_USE = 2'b01;
  localparam logic [1:0] STALL_MEM_WAIT = 2'b10;

  // Register-address compare; register 0 is deliberately not special-cased.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             srst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count state: reset/clear to zero, otherwise increment until all-ones.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (srst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_control_unit.sv
// Lapido stall/flush controller: load-use bubbles and data-memory wait freezes.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_control_unit
  import lapido_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_registerA,
  input  logic [REG_ADDR_W-1:0] id_registerB,
  input  logic                  id_useB,
  input  logic                  id_memRead,
  input  logic                  id_memWrite,
  input  logic [REG_ADDR_W-1:0] id_registerRD,
  input  logic                  branch_flush,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic                  mem_wb_flush,
  output logic [1:0]            stall_cause,
  output logic [CNT_W-1:0]      load_use_count,
  output logic [CNT_W-1:0]      mem_wait_count
);

  logic                  ex_vld_r;
  logic                  ex_load_r;
  logic                  ex_acc_r;
  logic [REG_ADDR_W-1:0] ex_rd_r;
  logic                  mem_vld_r;
  logic                  mem_acc_r;
  logic                  mem_wait_s;
  logic                  load_use_s;
  logic [1:0]            cause_s;

  assign mem_wait_s = mem_vld_r && mem_acc_r && !mem_ready;
  assign load_use_s = id_valid && !branch_flush && ex_vld_r && ex_load_r &&
                      (reg_match(ex_rd_r, id_registerA) ||
                       (id_useB && reg_match(ex_rd_r, id_registerB)));

  // Shadow copy of EX/MEM memory-instruction info, advancing with the pipeline enables.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_vld_r  <= 1'b0;
      ex_load_r <= 1'b0;
      ex_acc_r  <= 1'b0;
      ex_rd_r   <= {REG_ADDR_W{1'b0}};
      mem_vld_r <= 1'b0;
      mem_acc_r <= 1'b0;
    end else begin
      if (id_ex_write) begin
        if (id_ex_flush || branch_flush || !id_valid) begin
          ex_vld_r  <= 1'b0;
          ex_load_r <= 1'b0;
          ex_acc_r  <= 1'b0;
          ex_rd_r   <= {REG_ADDR_W{1'b0}};
        end else begin
          ex_vld_r  <= 1'b1;
          ex_load_r <= id_memRead;
          ex_acc_r  <= id_memRead || id_memWrite;
          ex_rd_r   <= id_registerRD;
        end
      end
      if (ex_mem_write) begin
        mem_vld_r <= ex_vld_r;
        mem_acc_r <= ex_acc_r;
      end
    end
  end

  // Stall arbitration (MEM_WAIT over LOAD_USE over RUN) and pipeline controls.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    if (mem_wait_s) begin
      cause_s = STALL_MEM_WAIT;
    end else if (load_use_s) begin
      cause_s = STALL_LOAD_USE;
    end else begin
      cause_s = STALL_RUN;
    end
    case (cause_s)
      STALL_MEM_WAIT: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_flush = 1'b1;
      end
      STALL_LOAD_USE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

  assign stall_cause = cause_s;

`ifdef HAZARD_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .srst    (1'b0),
    .en      (cause_s == STALL_LOAD_USE),
    .count   (load_use_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .srst    (1'b0),
    .en      (cause_s == STALL_MEM_WAIT),
    .count   (mem_wait_count)
  );
`else
  assign load_use_count = {CNT_W{1'b0}};
  assign mem_wait_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Table-driven self-checking bench for hazard_control_unit with an expected-value queue.
module tb_hazard_control_unit;

  localparam int CNT_W = 16;
  localparam logic [7:0] RUN = 8'b1110_1000;
  localparam logic [7:0] LU  = 8'b0011_1001;
  localparam logic [7:0] MW  = 8'b0000_0110;
  localparam logic [7:0] NC  = 8'b0000_0000;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       useb;
    logic       mr;
    logic       mw;
    logic [3:0] rd;
    logic       bf;
    logic       rdy;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic id_valid = 1'b0, id_useB = 1'b0, id_memRead = 1'b0, id_memWrite = 1'b0;
  logic [3:0] id_registerA = 4'd0, id_registerB = 4'd0, id_registerRD = 4'd0;
  logic branch_flush = 1'b0, mem_ready = 1'b1;
  logic pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
  logic [1:0] stall_cause;
  logic [CNT_W-1:0] load_use_count, mem_wait_count;

  int total = 0;
  int bad = 0;
  int exp_lu = 0;
  int exp_mw = 0;
  bit cnt_known = 1'b0;
  logic [7:0] sb_q[$];
  vec_t tbl[$];

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_registerA(id_registerA), .id_registerB(id_registerB), .id_useB(id_useB),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_registerRD(id_registerRD),
    .branch_flush(branch_flush), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
    .stall_cause(stall_cause), .load_use_count(load_use_count),
    .mem_wait_count(mem_wait_count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst_n, input logic vld, input logic [3:0] ra,
                              input logic [3:0] rb, input logic useb, input logic mr,
                              input logic mw, input logic [3:0] rd, input logic bf,
                              input logic rdy, input logic chk, input logic [7:0] exp);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.ra = ra; v.rb = rb; v.useb = useb;
    v.mr = mr; v.mw = mw; v.rd = rd; v.bf = bf; v.rdy = rdy; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic run_row(input int idx, input vec_t v);
    logic [7:0] want;
    logic [7:0] got;
    int lu_req;
    int mw_req;
    @(negedge clock);
    reset_n = v.rst_n; id_valid = v.vld; id_registerA = v.ra; id_registerB = v.rb;
    id_useB = v.useb; id_memRead = v.mr; id_memWrite = v.mw; id_registerRD = v.rd;
    branch_flush = v.bf; mem_ready = v.rdy;
    if (v.chk) sb_q.push_back(v.exp);
    #2;
    if (v.chk) begin
      want = sb_q.pop_front();
      got = {pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_write,
             mem_wb_flush, stall_cause};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL row%0d ctrl got=%b want=%b", idx, got, want);
      end
    end
    if (cnt_known) begin
      lu_req = STATS ? exp_lu : 0;
      mw_req = STATS ? exp_mw : 0;
      total += 2;
      if (load_use_count !== CNT_W'(lu_req)) begin
        bad++;
        $display("FAIL row%0d load_use_count got=%0d want=%0d", idx, load_use_count, lu_req);
      end
      if (mem_wait_count !== CNT_W'(mw_req)) begin
        bad++;
        $display("FAIL row%0d mem_wait_count got=%0d want=%0d", idx, mem_wait_count, mw_req);
      end
    end
    if (!v.rst_n) begin
      exp_lu = 0; exp_mw = 0; cnt_known = 1'b1;
    end else if (v.exp == LU) begin
      exp_lu++;
    end else if (v.exp == MW) begin
      exp_mw++;
    end
  endtask

  initial begin
    //                rst vld ra rb uB mr mw rd bf rdy chk exp
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NC));   // reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN));  // post-reset state
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 3, 0, 1, 1, RUN));  // lw r3
    tbl.push_back(mk(1, 1, 3, 1, 1, 0, 0, 5, 0, 1, 1, LU));   // add r5=r3+r1
    tbl.push_back(mk(1, 1, 3, 1, 1, 0, 0, 5, 0, 1, 1, RUN));  // add issues
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 3, 0, 1, 1, RUN));  // lw r3
    tbl.push_back(mk(1, 1, 4, 3, 0, 0, 0, 5, 0, 1, 1, RUN));  // addi, rB=3 unused
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MW));   // load waits x3
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MW));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MW));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN));
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 1, 1, RUN));  // sw
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 2, 0, 1, 1, RUN));  // lw r2
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 0, 6, 0, 0, 1, MW));   // dep in ID, sw waits
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 0, 6, 0, 0, 1, MW));
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 0, 6, 0, 1, 1, LU));   // bubble after ready
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 0, 6, 0, 1, 1, RUN));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 7, 0, 1, 1, RUN));  // lw r7
    tbl.push_back(mk(1, 1, 7, 7, 1, 0, 0, 8, 1, 1, 1, RUN));  // dep squashed by branch
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MW));   // lw r7 waits
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NC));   // reset mid-stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUN));  // pending access forgotten
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, RUN));  // lw r1
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 9, 0, 1, 1, RUN));  // lw r9, r1 ready at once
    tbl.push_back(mk(1, 1, 1, 9, 1, 0, 0, 10, 0, 1, 1, LU));  // match via source B
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN));

    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    // Branch during a memory wait must not clear the held EX load.
    run_row(100, mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 1, 1, RUN));   // sw
    run_row(101, mk(1, 1, 0, 0, 0, 1, 0, 4, 0, 1, 1, RUN));   // lw r4
    run_row(102, mk(1, 1, 4, 0, 1, 0, 0, 5, 1, 0, 1, MW));    // wait, branch ignored
    run_row(103, mk(1, 1, 4, 0, 1, 0, 0, 5, 0, 1, 1, LU));    // load r4 still in EX
    run_row(104, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
